// File: rtl/rv32_lsu_pkg.sv
// rtl/rv32_lsu_pkg.sv - shared types and constants for the RV32 memory-stage LSU
// Purpose : funct3 encodings, writeback-select and FSM state enums, and the
//           access legality check shared by the LSU datapath.
// Ports   : none (package).
package rv32_lsu_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_PC4  = 2'd2,
      WB_NONE = 2'd3
   } wb_sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } lsu_state_t;

   // True when funct3 is legal for the op type and the address is naturally
   // aligned for the access size. Unsigned sizes exist only for loads.
   function automatic logic access_ok(input logic       is_store,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
      logic ok;
      case (funct3)
         LB:      ok = 1'b1;
         LH:      ok = ~addr_lo[0];
         LW:      ok = (addr_lo == 2'b00);
         LBU:     ok = ~is_store;
         LHU:     ok = ~is_store & ~addr_lo[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects and extends the addressed lane of a load word
// Purpose : combinational byte/halfword lane pick with sign/zero extension.
// Ports   : i_rdata   - 32-bit word returned by data memory
//           i_addr_lo - byte offset of the access within the word
//           i_funct3  - RV32I load funct3 (size and signedness)
//           o_data    - aligned, extended load result
module load_align
   import rv32_lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_addr_lo)
         2'd0: w_byte = i_rdata[7:0];
         2'd1: w_byte = i_rdata[15:8];
         2'd2: w_byte = i_rdata[23:16];
         2'd3: w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

      case (i_funct3)
         LB:      o_data = {{24{w_byte[7]}}, w_byte};
         LH:      o_data = {{16{w_half[15]}}, w_half};
         LBU:     o_data = {24'd0, w_byte};
         LHU:     o_data = {16'd0, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/memory_stage_lsu.sv
// rtl/memory_stage_lsu.sv - RV32IM memory stage: load/store unit and writeback register
// Purpose : accepts execute-stage results, runs one data-memory access at a
//           time over a req/ack handshake, and registers the writeback value.
// Ports   : clk, rst             - clock, asynchronous active-high reset
//           valid_i ... wb_sel_i  - execute-stage result and control
//           stall_o               - upstream must not present a new instruction
//           wb_data_o/wb_valid_o  - registered writeback value and its pulse
//           fault_o               - misaligned access or illegal funct3 pulse
//           dmem_*                - data-memory request/response channel
module memory_stage_lsu
   import rv32_lsu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] alu_res_i,
   input  logic [DATA_WIDTH-1:0] store_data_i,
   input  logic [DATA_WIDTH-1:0] next_sel_address_i,
   input  logic                  mem_read_i,
   input  logic                  mem_write_i,
   input  logic [2:0]            funct3_i,
   input  logic [1:0]            wb_sel_i,
   output logic                  stall_o,
   output logic [DATA_WIDTH-1:0] wb_data_o,
   output logic                  wb_valid_o,
   output logic                  fault_o,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [ADDR_WIDTH-1:0] dmem_addr_o,
   output logic [DATA_WIDTH-1:0] dmem_wdata_o,
   output logic [3:0]            dmem_wstrb_o,
   input  logic                  dmem_ack_i,
   input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);

   lsu_state_t            r_state;
   lsu_state_t            w_next_state;
   logic                  r_is_store;
   logic [2:0]            r_funct3;
   logic [1:0]            r_lane;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [3:0]            r_wstrb;
   logic [DATA_WIDTH-1:0] r_wb_data;
   logic                  r_wb_valid;
   logic                  r_fault;

   logic                  w_mem_op;
   logic                  w_ok;
   logic                  w_accept;
   logic                  w_fault;
   logic [3:0]            w_wstrb;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_load_data;

   // A store wins when both read and write are flagged.
   assign w_mem_op = mem_read_i | mem_write_i;
   assign w_ok     = access_ok(mem_write_i, funct3_i, alu_res_i[1:0]);

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_fault      = 1'b0;
      case (r_state)
         IDLE: begin
            if (valid_i && w_mem_op) begin
               if (w_ok) begin
                  w_accept     = 1'b1;
                  w_next_state = BUSY;
               end else begin
                  w_fault = 1'b1;
               end
            end
         end
         BUSY: begin
            if (dmem_ack_i) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Lane placement is resolved at accept time so the request stays stable.
   always_comb begin
      w_wstrb = 4'b0000;
      w_wdata = '0;
      if (mem_write_i) begin
         case (funct3_i)
            SB: begin
               w_wstrb = 4'b0001 << alu_res_i[1:0];
               w_wdata = {4{store_data_i[7:0]}};
            end
            SH: begin
               w_wstrb = 4'b0011 << {alu_res_i[1], 1'b0};
               w_wdata = {2{store_data_i[15:0]}};
            end
            default: begin
               w_wstrb = 4'b1111;
               w_wdata = store_data_i;
            end
         endcase
      end
   end

   load_align u_load_align (
      .i_rdata   (dmem_rdata_i),
      .i_addr_lo (r_lane),
      .i_funct3  (r_funct3),
      .o_data    (w_load_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_is_store <= 1'b0;
         r_funct3   <= 3'b000;
         r_lane     <= 2'b00;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wstrb    <= 4'b0000;
         r_wb_data  <= '0;
         r_wb_valid <= 1'b0;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_wb_valid <= 1'b0;
         r_fault    <= w_fault;

         if (w_accept) begin
            r_is_store <= mem_write_i;
            r_funct3   <= funct3_i;
            r_lane     <= alu_res_i[1:0];
            r_addr     <= {alu_res_i[ADDR_WIDTH-1:2], 2'b00};
            r_wdata    <= w_wdata;
            r_wstrb    <= w_wstrb;
         end

         if (r_state == IDLE && valid_i && !w_mem_op) begin
            case (wb_sel_t'(wb_sel_i))
               WB_ALU: begin
                  r_wb_data  <= alu_res_i;
                  r_wb_valid <= 1'b1;
               end
               WB_PC4: begin
                  r_wb_data  <= next_sel_address_i;
                  r_wb_valid <= 1'b1;
               end
               default: r_wb_data <= '0;
            endcase
         end

         if (r_state == BUSY && dmem_ack_i && !r_is_store) begin
            r_wb_data  <= w_load_data;
            r_wb_valid <= 1'b1;
         end
      end
   end

   assign stall_o      = (r_state == BUSY) | w_accept;
   assign dmem_req_o   = (r_state == BUSY);
   assign dmem_we_o    = (r_state == BUSY) & r_is_store;
   assign dmem_addr_o  = r_addr;
   assign dmem_wdata_o = r_wdata;
   assign dmem_wstrb_o = r_wstrb;
   assign wb_data_o    = r_wb_data;
   assign wb_valid_o   = r_wb_valid;
   assign fault_o      = r_fault;

endmodule

// File: tb/tb_memory_stage_lsu.sv
// tb/tb_memory_stage_lsu.sv - scoreboard bench for memory_stage_lsu
module tb_memory_stage_lsu;
   import rv32_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic [31:0] alu_res_i = '0;
   logic [31:0] store_data_i = '0;
   logic [31:0] next_sel_address_i = '0;
   logic        mem_read_i = 1'b0;
   logic        mem_write_i = 1'b0;
   logic [2:0]  funct3_i = '0;
   logic [1:0]  wb_sel_i = '0;
   logic        stall_o;
   logic [31:0] wb_data_o;
   logic        wb_valid_o;
   logic        fault_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_wstrb_o;
   logic        dmem_ack_i = 1'b0;
   logic [31:0] dmem_rdata_i = '0;

   memory_stage_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .alu_res_i(alu_res_i),
      .store_data_i(store_data_i), .next_sel_address_i(next_sel_address_i),
      .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
      .wb_sel_i(wb_sel_i), .stall_o(stall_o), .wb_data_o(wb_data_o),
      .wb_valid_o(wb_valid_o), .fault_o(fault_o), .dmem_req_o(dmem_req_o),
      .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
      .dmem_wstrb_o(dmem_wstrb_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
   );

   always #5 clk = ~clk;

   typedef enum int {EV_WB, EV_FAULT, EV_REQ} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic [31:0] data;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } ev_t;

   ev_t         exp_q[$];
   int          exp_len_q[$];
   logic [31:0] model_mem[16];
   logic [31:0] resp_mem[16];
   int          force_delay = -1;
   bit          hold_ack = 1'b0;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   task automatic pop_ev(input ev_kind_t kind, output ev_t e, output bit ok);
      ok = 1'b0;
      e.kind = kind; e.data = '0; e.addr = '0; e.we = 1'b0; e.wdata = '0; e.wstrb = '0;
      if (exp_q.size() == 0) begin
         check("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
      end else begin
         e = exp_q.pop_front();
         check("event_kind", 32'(kind), 32'(e.kind));
         ok = (e.kind == kind);
      end
   endtask

   // Reference rules: access size from funct3, natural alignment, lane extraction.
   function automatic int acc_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit legal_op(input bit st, input logic [2:0] f3, input logic [31:0] a);
      if (st && f3 > 3'd2) return 1'b0;
      if (!st && (f3 == 3'd3 || f3 > 3'd5)) return 1'b0;
      return (a % acc_size(f3)) == 0;
   endfunction

   function automatic logic [31:0] load_val(input logic [31:0] word, input logic [2:0] f3,
                                            input logic [31:0] a);
      int          sz  = acc_size(f3);
      int          off = int'(a % 4);
      logic [31:0] mask, v;
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
      v = (word >> (8 * off)) & mask;
      if (f3 < 3'd4 && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
      return v;
   endfunction

   task automatic wait_idle();
      int guard = 0;
      while (stall_o && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (stall_o) check("stall_timeout", 32'(stall_o), 32'd0);
   endtask

   task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4,
                        input bit rd, input bit wr, input logic [2:0] f3, input logic [1:0] ws);
      bit          mem_op = rd | wr;
      bit          ok;
      bit          none_chk = 1'b0;
      int          sz, off;
      logic [3:0]  idx;
      ev_t         e;
      wait_idle();
      valid_i = 1'b1; alu_res_i = alu; store_data_i = sd; next_sel_address_i = pc4;
      mem_read_i = rd; mem_write_i = wr; funct3_i = f3; wb_sel_i = ws;
      ok = mem_op && legal_op(wr, f3, alu);
      #1;
      check("stall_on_issue", 32'(stall_o), 32'(ok));
      e.kind = EV_WB; e.data = '0; e.addr = '0; e.we = 1'b0; e.wdata = '0; e.wstrb = '0;
      sz = acc_size(f3); off = int'(alu % 4); idx = alu[5:2];
      if (!mem_op) begin
         if (ws == 2'd0) begin e.data = alu; exp_q.push_back(e); end
         else if (ws == 2'd2) begin e.data = pc4; exp_q.push_back(e); end
         else none_chk = 1'b1;
      end else if (!ok) begin
         e.kind = EV_FAULT; exp_q.push_back(e);
      end else begin
         e.kind = EV_REQ; e.addr = alu & 32'hFFFF_FFFC; e.we = wr;
         if (wr) begin
            for (int i = 0; i < 4; i++) begin
               e.wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
               if (i >= off && i < off + sz) begin
                  e.wstrb[i] = 1'b1;
                  model_mem[idx][8*i +: 8] = sd[8*(i - off) +: 8];
               end
            end
            exp_q.push_back(e);
         end else begin
            exp_q.push_back(e);
            e.kind = EV_WB; e.data = load_val(model_mem[idx], f3, alu);
            exp_q.push_back(e);
         end
      end
      @(negedge clk);
      valid_i = 1'b0; alu_res_i = $urandom; mem_read_i = 1'($urandom); mem_write_i = 1'($urandom);
      funct3_i = 3'($urandom); wb_sel_i = 2'($urandom); store_data_i = $urandom;
      if (none_chk) begin
         check("wbsel3_valid", 32'(wb_valid_o), 32'd0);
         check("wbsel3_data", wb_data_o, 32'd0);
      end
   endtask

   // Memory responder: random latency, occasional stray acks while idle.
   initial begin
      int         wait_cnt = -1;
      logic [3:0] idx;
      forever begin
         @(negedge clk);
         dmem_ack_i = 1'b0;
         dmem_rdata_i = $urandom;
         if (rst) begin
            wait_cnt = -1;
            exp_len_q.delete();
         end else if (dmem_req_o) begin
            if (!hold_ack) begin
               if (wait_cnt < 0) begin
                  wait_cnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
                  exp_len_q.push_back(wait_cnt + 1);
               end
               if (wait_cnt == 0) begin
                  dmem_ack_i = 1'b1;
                  idx = dmem_addr_o[5:2];
                  if (dmem_we_o) begin
                     for (int i = 0; i < 4; i++)
                        if (dmem_wstrb_o[i]) resp_mem[idx][8*i +: 8] = dmem_wdata_o[8*i +: 8];
                  end else begin
                     dmem_rdata_i = resp_mem[idx];
                  end
                  wait_cnt = -1;
               end else begin
                  wait_cnt--;
               end
            end
         end else begin
            wait_cnt = -1;
            if ($urandom_range(0, 5) == 0) dmem_ack_i = 1'b1;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents a request, writeback or fault.
   initial begin
      bit   prev_req = 1'b0;
      bit   have_cur = 1'b0;
      bit   ok;
      int   req_len = 0;
      ev_t  cur, e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req = 1'b0; req_len = 0; have_cur = 1'b0;
         end else begin
            if (dmem_req_o) begin
               if (!prev_req) begin
                  pop_ev(EV_REQ, cur, have_cur);
                  req_len = 0;
               end
               if (have_cur) begin
                  check("req_addr", dmem_addr_o, cur.addr);
                  check("req_we", 32'(dmem_we_o), 32'(cur.we));
                  if (cur.we) begin
                     check("req_wdata", dmem_wdata_o, cur.wdata);
                     check("req_wstrb", 32'(dmem_wstrb_o), 32'(cur.wstrb));
                  end
               end
               check("stall_busy", 32'(stall_o), 32'd1);
               req_len++;
            end else if (prev_req && exp_len_q.size() > 0) begin
               check("req_length", 32'(req_len), 32'(exp_len_q.pop_front()));
            end
            prev_req = dmem_req_o;
            if (wb_valid_o) begin
               pop_ev(EV_WB, e, ok);
               if (ok) check("wb_data", wb_data_o, e.data);
            end
            if (fault_o) pop_ev(EV_FAULT, e, ok);
         end
      end
   end

   initial begin
      int         r;
      logic [31:0] a;
      logic [1:0]  ws;
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = $urandom;
         resp_mem[i] = model_mem[i];
      end
      repeat (3) @(negedge clk);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_wb_data", wb_data_o, 32'd0);
      check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
      check("rst_fault", 32'(fault_o), 32'd0);
      check("rst_req", 32'(dmem_req_o), 32'd0);
      check("rst_we", 32'(dmem_we_o), 32'd0);
      check("rst_addr", dmem_addr_o, 32'd0);
      check("rst_wdata", dmem_wdata_o, 32'd0);
      check("rst_wstrb", 32'(dmem_wstrb_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 2'd0);
      wait_idle();
      model_mem[0] = 32'h80FF_0000; resp_mem[0] = 32'h80FF_0000;
      force_delay = 2;
      issue(32'h0000_0103, 32'h0, 32'h0, 1'b1, 1'b0, LB, 2'd1);
      force_delay = -1;
      wait_idle();
      model_mem[0] = 32'hBEEF_0000; resp_mem[0] = 32'hBEEF_0000;
      issue(32'h0000_0202, 32'h0, 32'h0, 1'b1, 1'b0, LHU, 2'd1);
      issue(32'h0000_0301, 32'h0000_00A5, 32'h0, 1'b0, 1'b1, SB, 2'd3);
      issue(32'h0000_0402, 32'h0, 32'h0, 1'b1, 1'b0, LW, 2'd1);

      for (int n = 0; n < 300; n++) begin
         r = int'($urandom_range(0, 99));
         a = $urandom & 32'hFFFF_F03F;
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         if (r < 30) begin
            r = int'($urandom_range(0, 2));
            ws = (r == 0) ? 2'd0 : (r == 1) ? 2'd2 : 2'd3;
            issue($urandom, $urandom, $urandom, 1'b0, 1'b0, 3'($urandom), ws);
         end else if (r < 65) begin
            issue(a, $urandom, $urandom, 1'b1, 1'b0, 3'($urandom), 2'd1);
         end else if (r < 95) begin
            issue(a, $urandom, $urandom, 1'b0, 1'b1, 3'($urandom_range(0, 3)), 2'd3);
         end else begin
            issue(a, $urandom, $urandom, 1'b1, 1'b1, 3'($urandom_range(0, 3)), 2'd3);
         end
      end

      wait_idle();
      hold_ack = 1'b1;
      issue(32'h0000_0500, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, SW, 2'd3);
      @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_mid_req", 32'(dmem_req_o), 32'd0);
      check("rst_mid_stall", 32'(stall_o), 32'd0);
      check("rst_mid_wb_valid", 32'(wb_valid_o), 32'd0);
      repeat (2) @(negedge clk);
      check("rst_mid_fault", 32'(fault_o), 32'd0);
      hold_ack = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      issue(32'h0000_5A5A, 32'h0, 32'h0000_0504, 1'b0, 1'b0, 3'd0, 2'd2);

      for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
